// File: rtl/div_ctrl.sv
// div_ctrl: sequencing and sharing controller for the shared iterative 32-bit divider.
// Arbitrates two requesters round-robin, decodes DIV/DIVU/REM/REMU, resolves divide-by-zero
// and signed overflow without starting the divider, and returns results on a valid/ready port.
// Optional result cache enabled by defining DIV_CTRL_CACHE_EN.
module div_ctrl #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0]       req_op0,
  input  logic [1:0]       req_op1,
  input  logic [31:0]      req_a0,
  input  logic [31:0]      req_a1,
  input  logic [31:0]      req_b0,
  input  logic [31:0]      req_b1,
  input  logic [TAG_W-1:0] req_tag0,
  input  logic [TAG_W-1:0] req_tag1,
  output logic             div_start,
  output logic             div_signed,
  output logic [31:0]      div_dividend,
  output logic [31:0]      div_divisor,
  input  logic [31:0]      div_quotient,
  input  logic [31:0]      div_remainder,
  input  logic             div_done,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic             resp_id,
  output logic [TAG_W-1:0] resp_tag
);

  typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_e;

  state_e           state_q, state_d;
  logic             rr_q, rr_d;
  logic [1:0]       op_q, op_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             id_q, id_d;
  logic             sgn_q, sgn_d;
  logic [31:0]      data_q, data_d;

  // Grant and selected request
  logic             gnt_vld;
  logic             gnt_id;
  logic             accept;
  logic [1:0]       sel_op;
  logic [31:0]      sel_a;
  logic [31:0]      sel_b;
  logic [TAG_W-1:0] sel_tag;

  // Fast-path decode on raw operands
  logic             b_zero;
  logic             sgn_ovf;
  logic             fast_vld;
  logic [31:0]      fast_data;

  // Cache lookup result (constant miss when the cache is not built)
  logic             cache_hit;
  logic [31:0]      cache_data;

  // Round-robin grant: a lone requester wins; on contention rr_q names the favoured one
  always_comb begin
    gnt_vld = |req_valid;
    gnt_id  = 1'b0;
    case (req_valid)
      2'b01:   gnt_id = 1'b0;
      2'b10:   gnt_id = 1'b1;
      2'b11:   gnt_id = rr_q;
      default: gnt_id = 1'b0;
    endcase
  end

  assign accept = (state_q == StIdle) && gnt_vld;

  // Operand mux for the granted requester
  always_comb begin
    sel_op  = gnt_id ? req_op1  : req_op0;
    sel_a   = gnt_id ? req_a1   : req_a0;
    sel_b   = gnt_id ? req_b1   : req_b0;
    sel_tag = gnt_id ? req_tag1 : req_tag0;
  end

  // Special cases the divider never sees; overflow only applies to signed ops (op[0]=0)
  always_comb begin
    b_zero    = (sel_b == 32'h0000_0000);
    sgn_ovf   = !sel_op[0] && (sel_a == 32'h8000_0000) && (sel_b == 32'hFFFF_FFFF);
    fast_vld  = b_zero || sgn_ovf;
    fast_data = 32'h0000_0000;
    if (b_zero) begin
      fast_data = sel_op[1] ? sel_a : 32'hFFFF_FFFF;
    end else if (sgn_ovf) begin
      fast_data = sel_op[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

`ifdef DIV_CTRL_CACHE_EN
  // Single-entry cache of the last normal-path division, keyed on {a, b, signed}
  logic        cache_vld_q, cache_vld_d;
  logic [31:0] cache_a_q, cache_a_d;
  logic [31:0] cache_b_q, cache_b_d;
  logic        cache_sgn_q, cache_sgn_d;
  logic [31:0] cache_quo_q, cache_quo_d;
  logic [31:0] cache_rem_q, cache_rem_d;

  // Lookup against the granted request
  always_comb begin
    cache_hit  = cache_vld_q && (cache_a_q == sel_a) && (cache_b_q == sel_b) &&
                 (cache_sgn_q == !sel_op[0]);
    cache_data = sel_op[1] ? cache_rem_q : cache_quo_q;
  end

  // Fill on every divider completion; both results kept so DIV-then-REM hits
  always_comb begin
    cache_vld_d = cache_vld_q;
    cache_a_d   = cache_a_q;
    cache_b_d   = cache_b_q;
    cache_sgn_d = cache_sgn_q;
    cache_quo_d = cache_quo_q;
    cache_rem_d = cache_rem_q;
    if ((state_q == StWait) && div_done) begin
      cache_vld_d = 1'b1;
      cache_a_d   = a_q;
      cache_b_d   = b_q;
      cache_sgn_d = sgn_q;
      cache_quo_d = div_quotient;
      cache_rem_d = div_remainder;
    end
  end

  // Cache storage; only reset invalidates
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_vld_q <= 1'b0;
      cache_a_q   <= 32'h0;
      cache_b_q   <= 32'h0;
      cache_sgn_q <= 1'b0;
      cache_quo_q <= 32'h0;
      cache_rem_q <= 32'h0;
    end else begin
      cache_vld_q <= cache_vld_d;
      cache_a_q   <= cache_a_d;
      cache_b_q   <= cache_b_d;
      cache_sgn_q <= cache_sgn_d;
      cache_quo_q <= cache_quo_d;
      cache_rem_q <= cache_rem_d;
    end
  end
`else
  assign cache_hit  = 1'b0;
  assign cache_data = 32'h0000_0000;
`endif

  // Next-state and capture logic for the sequencing FSM
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    id_d    = id_q;
    sgn_d   = sgn_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d  = sel_op;
          a_d   = sel_a;
          b_d   = sel_b;
          tag_d = sel_tag;
          id_d  = gnt_id;
          sgn_d = !sel_op[0];
          rr_d  = !gnt_id;
          if (fast_vld) begin
            data_d  = fast_data;
            state_d = StResp;
          end else if (cache_hit) begin
            data_d  = cache_data;
            state_d = StResp;
          end else begin
            state_d = StStart;
          end
        end
      end
      StStart: begin
        state_d = StWait;
      end
      StWait: begin
        if (div_done) begin
          data_d  = op_q[1] ? div_remainder : div_quotient;
          state_d = StResp;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and request-context registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rr_q    <= 1'b0;
      op_q    <= 2'b00;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      tag_q   <= '0;
      id_q    <= 1'b0;
      sgn_q   <= 1'b0;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      id_q    <= id_d;
      sgn_q   <= sgn_d;
      data_q  <= data_d;
    end
  end

  // Outputs decoded from state and registered context
  always_comb begin
    req_ready = 2'b00;
    if (accept) begin
      req_ready = gnt_id ? 2'b10 : 2'b01;
    end
    div_start    = (state_q == StStart);
    div_signed   = sgn_q;
    div_dividend = a_q;
    div_divisor  = b_q;
    resp_valid   = (state_q == StResp);
    resp_data    = data_q;
    resp_id      = id_q;
    resp_tag     = tag_q;
  end

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed vectors, expected responses queued at issue
// and compared by a monitor at each response handshake. Includes a behavioural divider.
module tb_div_ctrl;
  localparam int unsigned TAG_W = 4;
  localparam int LAT = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_op0, req_op1;
  logic [31:0]      req_a0, req_a1, req_b0, req_b1;
  logic [TAG_W-1:0] req_tag0, req_tag1;
  logic             div_start, div_signed;
  logic [31:0]      div_dividend, div_divisor;
  logic [31:0]      div_quotient, div_remainder;
  logic             div_done;
  logic             resp_valid, resp_ready;
  logic [31:0]      resp_data;
  logic             resp_id;
  logic [TAG_W-1:0] resp_tag;

  typedef struct packed {
    logic [31:0]      data;
    logic             id;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   start_cnt = 0;
  int   acc_cnt = 0;

`ifdef DIV_CTRL_CACHE_EN
  localparam bit CacheOn = 1'b1;
`else
  localparam bit CacheOn = 1'b0;
`endif

  div_ctrl #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
    .req_tag0(req_tag0), .req_tag1(req_tag1),
    .div_start(div_start), .div_signed(div_signed),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder), .div_done(div_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_tag(resp_tag)
  );

  always #5 clk = ~clk;

  // Behavioural divider: latches operands on start, raises done LAT cycles later
  logic [31:0] m_a, m_b;
  logic        m_sgn;
  int          m_cnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      div_done      <= 1'b0;
      m_cnt         <= 0;
      div_quotient  <= 32'h0;
      div_remainder <= 32'h0;
      m_a <= 32'h0; m_b <= 32'h1; m_sgn <= 1'b0;
    end else if (div_start) begin
      m_a <= div_dividend; m_b <= div_divisor; m_sgn <= div_signed;
      m_cnt    <= LAT;
      div_done <= 1'b0;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        div_done <= 1'b1;
        if (m_sgn) begin
          div_quotient  <= $signed(m_a) / $signed(m_b);
          div_remainder <= $signed(m_a) % $signed(m_b);
        end else begin
          div_quotient  <= m_a / m_b;
          div_remainder <= m_a % m_b;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] data, input logic id, input logic [TAG_W-1:0] tag);
    exp_t e;
    e.data = data; e.id = id; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #2;
  endtask

  // Issue one request, check accept-to-response timing and divider start count
  task automatic send(input logic id, input logic [1:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [TAG_W-1:0] tag,
                      input logic [31:0] exp, input bit fast);
    int s0;
    bit got;
    s0 = start_cnt;
    push(exp, id, tag);
    if (id) begin
      req_op1 = op; req_a1 = a; req_b1 = b; req_tag1 = tag;
    end else begin
      req_op0 = op; req_a0 = a; req_b0 = b; req_tag0 = tag;
    end
    req_valid[id] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[id]) begin got = 1'b1; break; end
    end
    chk("accept", 32'(got), 32'd1);
    @(posedge clk); #2;
    req_valid[id] = 1'b0;
    @(negedge clk);
    chk("resp_valid_after_accept", 32'(resp_valid), 32'(fast));
    chk("div_start_after_accept", 32'(div_start), 32'(!fast));
    if (!fast) chk("div_signed", 32'(div_signed), 32'(!op[0]));
    drain();
    chk("start_count", 32'(start_cnt - s0), fast ? 32'd0 : 32'd1);
  endtask

  initial begin
    bit got;
    int base;
    rst = 1'b1; req_valid = 2'b00; resp_ready = 1'b1;
    req_op0 = 2'b00; req_op1 = 2'b00; req_a0 = 32'h0; req_a1 = 32'h0;
    req_b0 = 32'h0; req_b1 = 32'h0; req_tag0 = '0; req_tag1 = '0;

    fork
      // Scoreboard monitor: one compare per handshake
      forever begin
        exp_t e;
        @(negedge clk);
        if (resp_valid && resp_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_resp", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("resp_data", resp_data, e.data);
            chk("resp_id", 32'(resp_id), 32'(e.id));
            chk("resp_tag", 32'(resp_tag), 32'(e.tag));
          end
        end
      end
      // Event counters
      forever begin
        @(negedge clk);
        if (div_start === 1'b1) start_cnt++;
        if ((req_ready & req_valid) != 2'b00) acc_cnt++;
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_div_start", 32'(div_start), 32'd0);
    chk("rst_div_signed", 32'(div_signed), 32'd0);
    chk("rst_div_dividend", div_dividend, 32'd0);
    chk("rst_div_divisor", div_divisor, 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_tag", 32'(resp_tag), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    send(1'b0, 2'b01, 32'd100, 32'd7, 4'h3, 32'd14, 1'b0);
    send(1'b1, 2'b10, 32'hFFFF_FF9C, 32'd7, 4'h5, 32'hFFFF_FFFE, 1'b0);
    send(1'b0, 2'b00, 32'd1234, 32'd0, 4'h6, 32'hFFFF_FFFF, 1'b1);
    send(1'b1, 2'b11, 32'd55, 32'd0, 4'h7, 32'd55, 1'b1);
    send(1'b0, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 4'h8, 32'h8000_0000, 1'b1);
    send(1'b1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 4'h9, 32'h0, 1'b1);
    send(1'b1, 2'b00, 32'd7, 32'hFFFF_FFFE, 4'hC, 32'hFFFF_FFFD, 1'b0);

    // Contention with back-pressure: reset first so rr pointer favours requester 0
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    req_op0 = 2'b01; req_a0 = 32'd100; req_b0 = 32'd7; req_tag0 = 4'h1;
    req_op1 = 2'b11; req_a1 = 32'd100; req_b1 = 32'd7; req_tag1 = 4'h2;
    push(32'd14, 1'b0, 4'h1);
    push(32'd2, 1'b1, 4'h2);
    push(32'd14, 1'b0, 4'h1);
    push(32'd2, 1'b1, 4'h2);
    base = acc_cnt;
    resp_ready = 1'b0;
    req_valid = 2'b11;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (resp_valid) begin got = 1'b1; break; end
    end
    chk("stall_resp_seen", 32'(got), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_data", resp_data, 32'd14);
      chk("stall_id", 32'(resp_id), 32'd0);
      chk("stall_tag", 32'(resp_tag), 32'h1);
      chk("stall_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #2;
    resp_ready = 1'b1;
    for (int i = 0; i < 200 && acc_cnt < base + 4; i++) @(negedge clk);
    chk("stall_accepts", 32'(acc_cnt - base), 32'd4);
    @(posedge clk); #2;
    req_valid = 2'b00;
    drain();

    // DIV then REM on the same operands
    send(1'b0, 2'b00, 32'd1000, 32'd33, 4'hD, 32'd30, 1'b0);
    send(1'b1, 2'b10, 32'd1000, 32'd33, 4'hE, 32'd10, CacheOn);

    // Reset while waiting on the divider
    req_op0 = 2'b01; req_a0 = 32'd5000; req_b0 = 32'd3; req_tag0 = 4'hA;
    req_valid = 2'b01;
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready[0]) begin got = 1'b1; break; end
    end
    chk("wait_rst_accept", 32'(got), 32'd1);
    @(posedge clk); #2;
    req_valid = 2'b00;
    @(posedge clk); #2;
    rst = 1'b1;
    req_valid = 2'b01;
    @(negedge clk);
    chk("wait_rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("wait_rst_div_start", 32'(div_start), 32'd0);
    chk("wait_rst_idle_ready", 32'(req_ready), 32'd1);
    chk("wait_rst_dividend", div_dividend, 32'd0);
    @(posedge clk); #2;
    req_valid = 2'b00;
    rst = 1'b0;
    send(1'b0, 2'b11, 32'd5000, 32'd3, 4'hB, 32'd2, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Sequencing and sharing controller for the shared iterative 32-bit divider in the M-extension datapath. Arbitrates between two requesters (pipeline EX stage and a secondary issuer) with round-robin priority and decodes DIV/DIVU/REM/REMU. Resolves RISC-V special cases (divide-by-zero, signed overflow) without starting the divider. Drives the divider's start/operand pins and returns the selected result on a valid/ready response port.

## Interface
- TAG_W, 4, width of the opaque request tag echoed on the response
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  2  per-requester request valid; bit i = requester i
- req_ready  out  2  per-requester accept; at most one bit high
- req_op0, req_op1  in  2 each  00 DIV, 01 DIVU, 10 REM, 11 REMU
- req_a0, req_a1  in  32 each  dividend
- req_b0, req_b1  in  32 each  divisor
- req_tag0, req_tag1  in  TAG_W each  tag
- div_start  out  1  one-cycle start pulse to divider
- div_signed  out  1  signed mode to divider
- div_dividend, div_divisor  out  32 each  operands, held stable from START through WAIT
- div_quotient, div_remainder  in  32 each  divider results
- div_done  in  1  divider completion (level)
- resp_valid  out  1  response valid
- resp_ready  in  1  response accept
- resp_data  out  32  result
- resp_id  out  1  index of the requester that was served
- resp_tag  out  TAG_W  echoed tag

## Operation
- States: IDLE, START, WAIT, RESP.
- IDLE: req_ready asserted only for the granted requester. Grant goes to the single valid requester. If both are valid, the grant goes to the requester not served last (rr pointer; reset points to 0). The accept edge registers op, a, b, tag, id, and sets rr pointer to the loser.
- Fast path at accept, evaluated on the raw operands:
  - b==0: DIV/DIVU -> 32'hFFFFFFFF; REM/REMU -> a.
  - Signed overflow: DIV with a==32'h80000000, b==32'hFFFFFFFF -> 32'h80000000; REM with the same operands -> 0.
  - Fast-path requests go IDLE -> RESP; div_start is never asserted.
- Normal path: IDLE -> START. START drives div_start=1 for exactly one cycle, then moves to WAIT. div_signed = ~op[0].
- WAIT: div_done is sampled only in WAIT. On div_done=1, capture div_quotient (op[1]=0) or div_remainder (op[1]=1) into resp_data, then go to RESP.
- RESP: resp_valid=1. resp_data/id/tag are held stable while resp_ready=0. The handshake (resp_valid&resp_ready) returns to IDLE. There is no accept in the same cycle as the handshake.
- New requests arriving during START/WAIT/RESP are stalled: req_ready=0 and no state is captured.

## Timing
- Reset values: req_ready=0, div_start=0, div_signed=0, div_dividend=0, div_divisor=0, resp_valid=0, resp_data=0, resp_id=0, resp_tag=0, state IDLE, rr pointer 0.
- Fast path: accept at edge N, resp_valid high from cycle N+1.
- Normal path: accept edge N; div_start high in cycle N+1; WAIT from N+2. If div_done is first seen in cycle M, resp_valid goes high in cycle M+1.
- Back-to-back throughput: the earliest next accept is the cycle after the response handshake.
- Reset mid-operation (any state) returns to IDLE immediately and drops resp_valid and div_start. The divider shares rst, so no stale done survives.

## Configuration
- DIV_CTRL_CACHE_EN defined:
  - After every normal-path completion, store {a, b, signed} plus both quotient and remainder.
  - A later normal-path request with matching {a, b, signed} goes IDLE -> RESP with the cached value of the requested kind. This covers the DIV-then-REM idiom.
  - The cache is invalidated by reset only; fast-path requests neither hit nor fill it.
- DIV_CTRL_CACHE_EN undefined: no cache storage; every non-special request takes the normal path.

## Test plan
- Requester 0, DIVU a=100 b=7 -> one div_start pulse, div_signed=0; resp_data=14, resp_id=0, resp_tag echoed.
- Requester 1, REM a=-100 (32'hFFFFFF9C) b=7 -> div_signed=1; resp_data=32'hFFFFFFFE (-2).
- DIV b=0 and REMU a=55 b=0 -> no div_start; resp_data 32'hFFFFFFFF and 55 respectively, each one cycle after accept.
- DIV 32'h80000000 / 32'hFFFFFFFF -> no div_start; resp_data=32'h80000000. The matching REM returns 0.
- Both requesters valid continuously, resp_ready held low 5 cycles on the first response -> resp fields stable; grants alternate 0,1,0,1. Reset asserted during WAIT -> resp_valid=0 and IDLE next cycle.
- With DIV_CTRL_CACHE_EN: DIV 1000/33 then REM 1000/33 -> second response 10 with no div_start, one cycle after accept. Without the macro, the second request pulses div_start.
